fir_stream_engine: RTL

//  Parametrised FIR engine with internal tap/data storage; no external BRAMs. Coefficients, length
//  and control over AXI-Lite; samples in on AXI-Stream slave, results out on AXI-Stream master.
//  One MAC per cycle. Drop-in successor to the fixed 11-tap wrapper in the user project area.

---
 rtl/fir_pkg.sv | 36 +++
 rtl/fir_tap_regfile.sv | 51 +++++
 rtl/fir_stream_engine.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Package : fir_pkg
// Purpose : Shared definitions for the FIR stream engine: ap_ctrl bit
//           positions, AXI-Lite register offsets, the engine FSM state
//           encoding and a helper for sizing tap/buffer index fields.
// Rev     : 1.0  initial release
// ============================================================================
package fir_pkg;

  // ap_ctrl register bit positions
  localparam int c_AP_START_BIT = 0;
  localparam int c_AP_DONE_BIT  = 1;
  localparam int c_AP_IDLE_BIT  = 2;

  // AXI-Lite byte offsets
  localparam int unsigned c_ADDR_AP_CTRL  = 32'h00;
  localparam int unsigned c_ADDR_DATA_LEN = 32'h10;
  localparam int unsigned c_ADDR_TAP_BASE = 32'h40;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_WAIT_IN = 3'd2,
    S_MAC     = 3'd3,
    S_OUT     = 3'd4,
    S_DONE    = 3'd5
  } fir_state_e;

  // Index width able to address n entries (at least one bit).
  function automatic int fir_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_tap_regfile.sv
`default_nettype none
// ============================================================================
// Module  : fir_tap_regfile
// Purpose : Coefficient storage for the FIR engine. pTAP_NUM registers of
//           pDATA_WIDTH bits with one write port and two independent
//           combinational read ports (AXI-Lite readback and MAC datapath).
// Ports   : i_clk / i_rst_n          clock, asynchronous active-low reset
//           i_we, i_waddr, i_wdata   write port
//           i_axi_raddr / o_axi_rdata register readback port
//           i_mac_raddr / o_mac_rdata MAC coefficient port
// Rev     : 1.0  initial release
// ============================================================================
module fir_tap_regfile #(
  parameter int pDATA_WIDTH = 32,
  parameter int pTAP_NUM    = 11,
  parameter int pIDX_W      = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_we,
  input  logic [pIDX_W-1:0]      i_waddr,
  input  logic [pDATA_WIDTH-1:0] i_wdata,
  input  logic [pIDX_W-1:0]      i_axi_raddr,
  output logic [pDATA_WIDTH-1:0] o_axi_rdata,
  input  logic [pIDX_W-1:0]      i_mac_raddr,
  output logic [pDATA_WIDTH-1:0] o_mac_rdata
);

  logic [pDATA_WIDTH-1:0] r_taps [pTAP_NUM];

  // The index field can encode values beyond pTAP_NUM when pTAP_NUM is not
  // a power of two; those are treated as non-existent entries.
  function automatic logic in_range(input logic [pIDX_W-1:0] a);
    return {1'b0, a} < (pIDX_W+1)'(pTAP_NUM);
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < pTAP_NUM; i++) begin
        r_taps[i] <= '0;
      end
    end else if (i_we && in_range(i_waddr)) begin
      r_taps[i_waddr] <= i_wdata;
    end
  end

  assign o_axi_rdata = in_range(i_axi_raddr) ? r_taps[i_axi_raddr] : '0;
  assign o_mac_rdata = in_range(i_mac_raddr) ? r_taps[i_mac_raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/fir_stream_engine.sv
`default_nettype none
// ============================================================================
// Module  : fir_stream_engine
// Purpose : Parametrised single-MAC FIR filter. Coefficients, data length and
//           control are programmed over AXI-Lite; samples arrive on an
//           AXI-Stream slave and filtered results leave on an AXI-Stream
//           master. Taps and the sample history live in internal registers.
// Ports   : i_axis_clk, i_axis_rst_n       clock, async active-low reset
//           i_aw*/o_awready, i_w*/o_wready AXI-Lite write (no B channel)
//           i_ar*/o_arready, o_r*/i_rready AXI-Lite read
//           i_ss_*/o_ss_tready             input sample stream
//           o_sm_*/i_sm_tready             output result stream
// Map     : 0x00 ap_ctrl {2:idle RO, 1:done RO, 0:start W1 self-clear}
//           0x10 data_length, 0x40+4*i tap[i]
// Rev     : 1.0  initial release
// ============================================================================
module fir_stream_engine #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTAP_NUM    = 11,
  parameter int pLEN_WIDTH  = 16
) (
  input  logic                   i_axis_clk,
  input  logic                   i_axis_rst_n,
  // AXI-Lite write
  input  logic                   i_awvalid,
  output logic                   o_awready,
  input  logic [pADDR_WIDTH-1:0] i_awaddr,
  input  logic                   i_wvalid,
  output logic                   o_wready,
  input  logic [pDATA_WIDTH-1:0] i_wdata,
  // AXI-Lite read
  input  logic                   i_arvalid,
  output logic                   o_arready,
  input  logic [pADDR_WIDTH-1:0] i_araddr,
  output logic                   o_rvalid,
  input  logic                   i_rready,
  output logic [pDATA_WIDTH-1:0] o_rdata,
  // AXI-Stream in
  input  logic                   i_ss_tvalid,
  output logic                   o_ss_tready,
  input  logic [pDATA_WIDTH-1:0] i_ss_tdata,
  input  logic                   i_ss_tlast,
  // AXI-Stream out
  output logic                   o_sm_tvalid,
  input  logic                   i_sm_tready,
  output logic [pDATA_WIDTH-1:0] o_sm_tdata,
  output logic                   o_sm_tlast
);

  import fir_pkg::*;

  localparam int c_IDX_W = fir_idx_width(pTAP_NUM);

  // --------------------------------------------------------------------------
  // State and storage
  // --------------------------------------------------------------------------
  fir_state_e             r_state;
  fir_state_e             w_state_nxt;
  logic [c_IDX_W-1:0]     r_cnt;      // step counter for CLEAR and MAC
  logic [c_IDX_W-1:0]     r_head;     // slot of the most recent sample
  logic [pDATA_WIDTH-1:0] r_buf [pTAP_NUM];
  logic [pDATA_WIDTH-1:0] r_acc;
  logic [pLEN_WIDTH-1:0]  r_len;
  logic [pLEN_WIDTH-1:0]  r_count;    // results delivered in this run
  logic                   r_ap_done;
  logic                   r_rvalid;
  logic [pDATA_WIDTH-1:0] r_rdata;

  // The length register alone defines frame boundaries.
  logic w_unused;
  assign w_unused = i_ss_tlast;

  // --------------------------------------------------------------------------
  // Address decode helpers
  // --------------------------------------------------------------------------
  function automatic logic tap_hit(input logic [pADDR_WIDTH-1:0] a);
    logic [pADDR_WIDTH-1:0] off;
    off = a - pADDR_WIDTH'(c_ADDR_TAP_BASE);
    return (a >= pADDR_WIDTH'(c_ADDR_TAP_BASE)) && (off[1:0] == 2'b00) &&
           (off[pADDR_WIDTH-1:2] < (pADDR_WIDTH-2)'(pTAP_NUM));
  endfunction

  function automatic logic [c_IDX_W-1:0] tap_idx(input logic [pADDR_WIDTH-1:0] a);
    return c_IDX_W'((a - pADDR_WIDTH'(c_ADDR_TAP_BASE)) >> 2);
  endfunction

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  logic w_ap_idle;
  logic w_ap_done;
  logic w_wr_fire;
  logic w_start;
  logic w_wr_len;
  logic w_tap_we;
  logic w_rd_fire;
  logic w_rd_clr_done;
  logic w_cnt_last;
  logic w_last_out;

  // DONE is a one-cycle pass-through state that already counts as idle.
  assign w_ap_idle = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_ap_done = r_ap_done || (r_state == S_DONE);

  // Address and data are taken together; ready is offered only against a
  // presented pair so a quiescent bus shows both readies low.
  assign w_wr_fire = i_awvalid && i_wvalid;
  assign o_awready = w_wr_fire;
  assign o_wready  = w_wr_fire;

  assign w_start  = w_wr_fire && (i_awaddr == pADDR_WIDTH'(c_ADDR_AP_CTRL)) &&
                    i_wdata[c_AP_START_BIT] && w_ap_idle;
  assign w_wr_len = w_wr_fire && (i_awaddr == pADDR_WIDTH'(c_ADDR_DATA_LEN)) && w_ap_idle;
  assign w_tap_we = w_wr_fire && tap_hit(i_awaddr) && w_ap_idle;

  // One outstanding read at a time; accept whenever no response is pending.
  assign w_rd_fire     = i_arvalid && !r_rvalid;
  assign o_arready     = w_rd_fire;
  assign w_rd_clr_done = w_rd_fire && (i_araddr == pADDR_WIDTH'(c_ADDR_AP_CTRL));

  assign w_cnt_last = (r_cnt == c_IDX_W'(pTAP_NUM - 1));
  assign w_last_out = (r_count == r_len - pLEN_WIDTH'(1));

  // --------------------------------------------------------------------------
  // Tap register file
  // --------------------------------------------------------------------------
  logic [pDATA_WIDTH-1:0] w_tap_axi;
  logic [pDATA_WIDTH-1:0] w_tap_mac;

  fir_tap_regfile #(
    .pDATA_WIDTH (pDATA_WIDTH),
    .pTAP_NUM    (pTAP_NUM),
    .pIDX_W      (c_IDX_W)
  ) u_taps (
    .i_clk       (i_axis_clk),
    .i_rst_n     (i_axis_rst_n),
    .i_we        (w_tap_we),
    .i_waddr     (tap_idx(i_awaddr)),
    .i_wdata     (i_wdata),
    .i_axi_raddr (tap_idx(i_araddr)),
    .o_axi_rdata (w_tap_axi),
    .i_mac_raddr (r_cnt),
    .o_mac_rdata (w_tap_mac)
  );

  // --------------------------------------------------------------------------
  // AXI-Lite read path (captures the pre-write value on a same-cycle write)
  // --------------------------------------------------------------------------
  logic [pDATA_WIDTH-1:0] w_rd_data;

  always_comb begin
    w_rd_data = '0;
    if (i_araddr == pADDR_WIDTH'(c_ADDR_AP_CTRL)) begin
      w_rd_data[c_AP_DONE_BIT] = w_ap_done;
      w_rd_data[c_AP_IDLE_BIT] = w_ap_idle;
    end else if (i_araddr == pADDR_WIDTH'(c_ADDR_DATA_LEN)) begin
      w_rd_data = pDATA_WIDTH'(r_len);
    end else if (tap_hit(i_araddr)) begin
      // Coefficients are in use by the MAC while busy and are not exposed.
      w_rd_data = w_ap_idle ? w_tap_axi : '1;
    end
  end

  always_ff @(posedge i_axis_clk or negedge i_axis_rst_n) begin
    if (!i_axis_rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_rd_fire) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
    end else if (r_rvalid && i_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;

  // --------------------------------------------------------------------------
  // Configuration and status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_axis_clk or negedge i_axis_rst_n) begin
    if (!i_axis_rst_n) begin
      r_len     <= '0;
      r_ap_done <= 1'b0;
    end else begin
      if (w_wr_len) begin
        r_len <= i_wdata[pLEN_WIDTH-1:0];
      end
      // A status read that observes done also consumes it.
      if (w_start || w_rd_clr_done) begin
        r_ap_done <= 1'b0;
      end else if (r_state == S_DONE) begin
        r_ap_done <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge i_axis_clk or negedge i_axis_rst_n) begin
    if (!i_axis_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_ss_tready = 1'b0;
    o_sm_tvalid = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) begin
          w_state_nxt = (r_len == '0) ? S_DONE : S_CLEAR;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (w_cnt_last) w_state_nxt = S_WAIT_IN;
      end
      S_WAIT_IN: begin
        o_ss_tready = 1'b1;
        if (i_ss_tvalid) w_state_nxt = S_MAC;
      end
      S_MAC: begin
        if (w_cnt_last) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        o_sm_tvalid = 1'b1;
        if (i_sm_tready) w_state_nxt = w_last_out ? S_DONE : S_WAIT_IN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sample buffer and MAC datapath
  // --------------------------------------------------------------------------
  logic [c_IDX_W-1:0]     w_wr_ptr;
  logic [c_IDX_W-1:0]     w_rd_ptr;
  logic [pDATA_WIDTH-1:0] w_prod;

  assign w_wr_ptr = (r_head == c_IDX_W'(pTAP_NUM - 1)) ? '0 : r_head + c_IDX_W'(1);

  // (head - i) mod pTAP_NUM. The true result always fits c_IDX_W bits, so
  // modular arithmetic on the narrow field is exact (adding pTAP_NUM folds
  // to zero when pTAP_NUM is a power of two, which is also correct).
  assign w_rd_ptr = r_head - r_cnt + ((r_cnt > r_head) ? c_IDX_W'(pTAP_NUM) : '0);

  // Only the low pDATA_WIDTH bits of the signed product are kept.
  assign w_prod = $signed(w_tap_mac) * $signed(r_buf[w_rd_ptr]);

  always_ff @(posedge i_axis_clk or negedge i_axis_rst_n) begin
    if (!i_axis_rst_n) begin
      r_cnt   <= '0;
      r_head  <= c_IDX_W'(pTAP_NUM - 1);
      r_acc   <= '0;
      r_count <= '0;
      for (int i = 0; i < pTAP_NUM; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_cnt   <= '0;
            r_count <= '0;
            // First sample of a run lands in slot 0.
            r_head  <= c_IDX_W'(pTAP_NUM - 1);
          end
        end
        S_CLEAR: begin
          r_buf[r_cnt] <= '0;
          r_cnt        <= w_cnt_last ? '0 : r_cnt + c_IDX_W'(1);
        end
        S_WAIT_IN: begin
          if (i_ss_tvalid) begin
            r_buf[w_wr_ptr] <= i_ss_tdata;
            r_head          <= w_wr_ptr;
            r_cnt           <= '0;
            r_acc           <= '0;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod;
          r_cnt <= w_cnt_last ? '0 : r_cnt + c_IDX_W'(1);
        end
        S_OUT: begin
          if (i_sm_tready) r_count <= r_count + pLEN_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_sm_tdata = r_acc;
  assign o_sm_tlast = o_sm_tvalid && w_last_out;

endmodule
`default_nettype wire
